// File: rtl/byte_dram_ctrl.sv
// Word-to-byte sequencer between the 32-bit MDR datapath and the byte-wide data RAM.
// Optional per-byte ram_done timeout: define BYTE_DRAM_CTRL_TIMEOUT_EN.
module byte_dram_ctrl #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_nbytes,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_w_en,
  output logic              ram_r_en,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  input  logic              ram_done
);

  if (DATA_W % 8 != 0 || DATA_W < 32 || TIMEOUT < 1) begin : g_bad_params
    $error("byte_dram_ctrl: DATA_W must be a multiple of 8 and >= 32, TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic               we_q;
  logic [1:0]         nbytes_q;
  logic [1:0]         k_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic               timeout_c;

`ifdef BYTE_DRAM_CTRL_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_q;

  // Counts WAIT cycles without ram_done for the byte currently outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (state_q == ISSUE) begin
      tmo_q <= '0;
    end else if (state_q == WAIT && !ram_done) begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end

  assign timeout_c = (state_q == WAIT) && !ram_done && (tmo_q == TMO_W'(TIMEOUT - 1));
`else
  assign timeout_c = 1'b0;
`endif

  // Next state and read-byte accumulation.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE:  if (req_valid) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (ram_done) begin
          if (!we_q) acc_d[{k_q, 3'b000} +: 8] = ram_rdata;
          state_d = (k_q == nbytes_q) ? RESP : ISSUE;
        end else if (timeout_c) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and registered outputs; strobes and rsp_valid are single-cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      ram_addr  <= '0;
      ram_w_en  <= 1'b0;
      ram_r_en  <= 1'b0;
      ram_wdata <= '0;
      we_q      <= 1'b0;
      nbytes_q  <= '0;
      k_q       <= '0;
      wdata_q   <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      ram_w_en  <= 1'b0;
      ram_r_en  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            nbytes_q  <= req_nbytes;
            k_q       <= '0;
            acc_q     <= '0;
            wdata_q   <= req_wdata >> 8;
            ram_addr  <= req_addr;
            ram_wdata <= req_wdata[7:0];
            ram_w_en  <= req_we;
            ram_r_en  <= !req_we;
            req_ready <= 1'b0;
          end
        end
        WAIT: begin
          if (state_d == ISSUE) begin
            k_q       <= k_q + 2'd1;
            ram_addr  <= ram_addr + ADDR_W'(1);
            ram_wdata <= wdata_q[7:0];
            wdata_q   <= wdata_q >> 8;
            ram_w_en  <= we_q;
            ram_r_en  <= !we_q;
          end else if (state_d == RESP) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= we_q ? '0 : acc_d;
            rsp_err   <= timeout_c;
          end
        end
        RESP:    req_ready <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_dram_ctrl.sv
// Self-checking bench for byte_dram_ctrl: transaction-level model, RAM responder, directed tests.
module tb_byte_dram_ctrl;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [11:0] req_addr = '0;
  logic [1:0]  req_nbytes = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [11:0] ram_addr;
  logic        ram_w_en, ram_r_en;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = '0;
  logic        ram_done = 1'b0;

  byte_dram_ctrl #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_nbytes(req_nbytes), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_addr(ram_addr), .ram_w_en(ram_w_en), .ram_r_en(ram_r_en),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_done(ram_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Responder storage and the model's own view of memory.
  logic [7:0] ram  [4096];
  logic [7:0] mmem [4096];

  int cfg_delay = 1;
  int cfg_hang  = -1;
  bit cfg_spur  = 1'b0;

  // RAM responder: ram_done cfg_delay cycles after each strobe.
  bit          pend = 1'b0;
  int          cnt = 0;
  int          stb_idx = 0;
  logic [11:0] p_addr;
  logic        p_we;
  logic [7:0]  p_d;

  always @(negedge clk) begin
    ram_done  = 1'b0;
    ram_rdata = 8'($urandom);
    if (!rst_n) begin
      pend    = 1'b0;
      stb_idx = 0;
    end else begin
      if (rsp_valid) stb_idx = 0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          ram_done  = 1'b1;
          ram_rdata = ram[p_addr];
          if (p_we) ram[p_addr] = p_d;
          pend = 1'b0;
        end
      end
      if (ram_w_en || ram_r_en) begin
        if (stb_idx != cfg_hang) begin
          pend   = 1'b1;
          cnt    = cfg_delay;
          p_addr = ram_addr;
          p_we   = ram_w_en;
          p_d    = ram_wdata;
        end
        stb_idx++;
        if (cfg_spur) ram_done = 1'b1;
      end
    end
  end

  // Transaction model: expected strobes, response data/err and response cycle.
  typedef struct packed {
    logic [11:0] a;
    logic        we;
    logic [7:0]  d;
  } stb_t;

  stb_t        exp_q[$];
  int          cyc = 0;
  bit          m_busy = 1'b0;
  int          m_rsp_cyc = 0;
  int          n_acc = 0;
  logic [31:0] m_rdata;
  bit          m_err;
  int          acc_cycs[$];
  int          m_lat;
  bit          m_stop;
  logic [11:0] m_a;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      m_busy = 1'b0;
      exp_q.delete();
    end else if ((!m_busy || (cyc - 1 > m_rsp_cyc)) && req_valid) begin
      m_rdata = '0;
      m_err   = 1'b0;
      m_lat   = 0;
      m_stop  = 1'b0;
      for (int i = 0; i <= int'(req_nbytes); i++) begin
        if (!m_stop) begin
          m_a = 12'(req_addr + 12'(i));
          exp_q.push_back('{a: m_a, we: req_we, d: req_wdata[8*i +: 8]});
          if (i == cfg_hang) begin
            m_lat += 1 + TMO;
            m_err  = 1'b1;
            m_stop = 1'b1;
          end else begin
            m_lat += 1 + cfg_delay;
            if (req_we) mmem[m_a] = req_wdata[8*i +: 8];
            else        m_rdata[8*i +: 8] = mmem[m_a];
          end
        end
      end
      m_busy    = 1'b1;
      m_rsp_cyc = (cyc - 1) + m_lat + 1;
      acc_cycs.push_back(cyc - 1);
      n_acc++;
    end
  end

  // Per-cycle compare against the model.
  logic [20:0] stb_log[$];
  int          rsp_cycs[$];
  int          rsp_cnt = 0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  stb_t        e;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_ctrl", 32'({req_ready, rsp_valid, rsp_err, ram_w_en, ram_r_en}), 32'h10);
      chk("reset_ram", 32'({ram_addr, ram_wdata}), 32'h0);
      chk("reset_rdata", rsp_rdata, 32'h0);
    end else begin
      chk("req_ready", 32'(req_ready), 32'(!m_busy || cyc > m_rsp_cyc));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_busy && cyc == m_rsp_cyc));
      chk("strobe_excl", 32'(ram_w_en && ram_r_en), 32'h0);
      if (ram_w_en || ram_r_en) begin
        stb_log.push_back({ram_w_en, ram_wdata, ram_addr});
        chk("strobe_expected", 32'(exp_q.size() != 0), 32'h1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("strobe_addr", 32'(ram_addr), 32'(e.a));
          chk("strobe_dir", 32'({ram_w_en, ram_r_en}), 32'({e.we, !e.we}));
          if (e.we) chk("strobe_wdata", 32'(ram_wdata), 32'(e.d));
        end
      end
      if (rsp_valid && m_busy && cyc == m_rsp_cyc) begin
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", 32'(rsp_err), 32'(m_err));
        chk("strobes_left", 32'(exp_q.size()), 32'h0);
        rsp_cycs.push_back(cyc);
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
        rsp_cnt++;
      end
    end
  end

  task automatic issue(input logic we, input logic [11:0] a, input logic [1:0] nb,
                       input logic [31:0] wd);
    int n0, r0;
    n0 = n_acc;
    r0 = rsp_cnt;
    @(negedge clk);
    stb_log.delete();
    req_valid = 1'b1; req_we = we; req_addr = a; req_nbytes = nb; req_wdata = wd;
    for (int t = 0; t < 20 && n_acc == n0; t++) @(negedge clk);
    req_valid = 1'b0;
    chk("accepted", 32'(n_acc), 32'(n0 + 1));
    for (int t = 0; t < 300 && rsp_cnt == r0; t++) @(negedge clk);
    chk("responded", 32'(rsp_cnt), 32'(r0 + 1));
    @(negedge clk);
  endtask

  function automatic int last_lat();
    return rsp_cycs[rsp_cycs.size() - 1] - acc_cycs[acc_cycs.size() - 1];
  endfunction

  initial begin
    int n0, r0, rs, as;
    for (int i = 0; i < 4096; i++) begin
      ram[i]  = 8'(i * 37 + 11);
      mmem[i] = 8'(i * 37 + 11);
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // 4-byte write, done one cycle after each strobe.
    cfg_delay = 1;
    issue(1'b1, 12'h100, 2'd3, 32'hDEADBEEF);
    chk("wr_lat", 32'(last_lat()), 32'd9);
    chk("wr_err", 32'(last_err), 32'h0);
    chk("wr_stb0", 32'(stb_log[0]), 32'({1'b1, 8'hEF, 12'h100}));
    chk("wr_stb1", 32'(stb_log[1]), 32'({1'b1, 8'hBE, 12'h101}));
    chk("wr_stb2", 32'(stb_log[2]), 32'({1'b1, 8'hAD, 12'h102}));
    chk("wr_stb3", 32'(stb_log[3]), 32'({1'b1, 8'hDE, 12'h103}));
    chk("wr_ram", 32'({ram[12'h103], ram[12'h102], ram[12'h101], ram[12'h100]}), 32'hDEADBEEF);

    // Same bytes read back with a 3-cycle RAM latency.
    cfg_delay = 3;
    issue(1'b0, 12'h100, 2'd3, 32'h0);
    chk("rd_rdata", last_rdata, 32'hDEADBEEF);
    chk("rd_lat", 32'(last_lat()), 32'd17);

    // 2-byte read wrapping from the top of the address space.
    ram[12'hFFF] = 8'h12; mmem[12'hFFF] = 8'h12;
    ram[12'h000] = 8'h34; mmem[12'h000] = 8'h34;
    cfg_delay = 1;
    issue(1'b0, 12'hFFF, 2'd1, 32'h0);
    chk("wrap_rdata", last_rdata, 32'h00003412);
    chk("wrap_a0", 32'(stb_log[0][11:0]), 32'h0FFF);
    chk("wrap_a1", 32'(stb_log[1][11:0]), 32'h0000);
    chk("wrap_lat", 32'(last_lat()), 32'd5);

    // req_valid held through a busy 3-byte write, spurious ram_done during ISSUE.
    cfg_spur = 1'b1;
    n0 = n_acc;
    r0 = rsp_cnt;
    @(negedge clk);
    stb_log.delete();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h300; req_nbytes = 2'd2;
    req_wdata = 32'h00A1B2C3;
    for (int t = 0; t < 20 && n_acc == n0; t++) @(negedge clk);
    req_we = 1'b0; req_nbytes = 2'd0; req_wdata = '0;
    for (int t = 0; t < 60 && n_acc == n0 + 1; t++) @(negedge clk);
    req_valid = 1'b0;
    chk("busy_acc2", 32'(n_acc), 32'(n0 + 2));
    for (int t = 0; t < 300 && rsp_cnt < r0 + 2; t++) @(negedge clk);
    chk("busy_rsp2", 32'(rsp_cnt), 32'(r0 + 2));
    cfg_spur = 1'b0;
    rs = rsp_cycs.size();
    as = acc_cycs.size();
    chk("busy_strobes", 32'(stb_log.size()), 32'd4);
    chk("busy_lat1", 32'(rsp_cycs[rs - 2] - acc_cycs[as - 2]), 32'd7);
    chk("busy_gap", 32'(acc_cycs[as - 1] - rsp_cycs[rs - 2]), 32'd1);
    chk("busy_rd", last_rdata, 32'h000000C3);
    @(negedge clk);

    // Reset in the middle of a 4-byte read.
    cfg_delay = 3;
    n0 = n_acc;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h200; req_nbytes = 2'd3;
    for (int t = 0; t < 20 && n_acc == n0; t++) @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    r0 = rsp_cnt;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_ready", 32'(req_ready), 32'h1);
    chk("midrst_rdata", rsp_rdata, 32'h0);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_no_rsp", 32'(rsp_cnt), 32'(r0));

    ram[12'h010] = 8'h5A; mmem[12'h010] = 8'h5A;
    cfg_delay = 1;
    issue(1'b0, 12'h010, 2'd0, 32'h0);
    chk("post_rst_rdata", last_rdata, 32'h0000005A);
    chk("post_rst_lat", 32'(last_lat()), 32'd3);

`ifdef BYTE_DRAM_CTRL_TIMEOUT_EN
    // Second byte never completes: abort after TMO WAIT cycles.
    cfg_delay = 1;
    cfg_hang  = 1;
    issue(1'b0, 12'h100, 2'd3, 32'h0);
    cfg_hang  = -1;
    chk("tmo_err", 32'(last_err), 32'h1);
    chk("tmo_rdata", last_rdata, 32'h000000EF);
    chk("tmo_lat", 32'(last_lat()), 32'd12);
    chk("tmo_strobes", 32'(stb_log.size()), 32'd2);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, summary not printed");
    $fatal(1);
  end

endmodule

// File: doc/byte_dram_ctrl.md
Name: byte_dram_ctrl

Overview:
Sequencer between the processor's 32-bit memory datapath (MDR side) and the byte-wide data RAM (12-bit address, 8-bit data, `done` strobe).
- Accepts one word-level read or write request.
- Splits it into 1–4 consecutive byte accesses and waits for the RAM `done` strobe after each byte.
- For reads, assembles the bytes little-endian into a 32-bit response.
- Feeds the RAM directly and replaces hand-driven `w_en`/`r_en`/`address` in the processor test harness.

Parameters:
- ADDR_W, 12, byte address width of data RAM.
- DATA_W, 32, processor-side word width; must be a multiple of 8.
- TIMEOUT, 64, max cycles to wait for `ram_done` per byte (used only with the optional feature).

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, 1, request present.
- req_ready, output, 1, controller can accept a request.
- req_we, input, 1, 1 = write, 0 = read.
- req_addr, input, ADDR_W, byte address of first byte.
- req_nbytes, input, 2, byte count minus 1 (0 = 1 byte … 3 = 4 bytes).
- req_wdata, input, DATA_W, write data; byte k = bits [8k+7:8k].
- rsp_valid, output, 1, one-cycle pulse when request completes.
- rsp_rdata, output, DATA_W, read data, zero-extended above the last byte read.
- rsp_err, output, 1, error flag qualified by rsp_valid (always 0 without the optional feature).
- ram_addr, output, ADDR_W, RAM byte address.
- ram_w_en, output, 1, RAM write strobe.
- ram_r_en, output, 1, RAM read strobe.
- ram_wdata, output, 8, byte to RAM.
- ram_rdata, input, 8, byte from RAM; valid in the cycle ram_done=1.
- ram_done, input, 1, RAM completion strobe for the current access.

Behaviour:
- Reset: asynchronous on rst_n low; clears regardless of the current state.
  - State = IDLE.
  - req_ready=1.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - ram_w_en=0, ram_r_en=0.
  - ram_addr=0, ram_wdata=0.
  - Internal counters = 0.
  - A transaction in flight is abandoned with no response.
- States:
  - IDLE:
    - req_ready=1.
    - On req_valid, latch we/addr/nbytes/wdata, clear byte index k=0, clear rdata accumulator, go to ISSUE.
    - req_ready drops the cycle after acceptance.
  - ISSUE (1 cycle):
    - Drive ram_addr = (addr+k) mod 2^ADDR_W; wrap 4095→0 for ADDR_W=12.
    - ram_wdata = wdata byte k.
    - Assert ram_w_en (write) or ram_r_en (read) for exactly this cycle.
    - Go to WAIT.
  - WAIT:
    - Strobes low; ram_addr and ram_wdata held.
    - On ram_done: for reads, store ram_rdata into accumulator byte k.
    - If k == nbytes, go to RESP; else k++ and go to ISSUE.
  - RESP:
    - rsp_valid=1 for one cycle; rsp_rdata = accumulator (writes return 0).
    - Go to IDLE.
- Latency, no RAM stall: acceptance → rsp_valid = 2·(nbytes+1)+1 cycles when ram_done arrives in the first WAIT cycle.
  - Example: a 4-byte read with immediate done completes in 9 cycles.
- ram_done outside WAIT is ignored.
- req_valid while busy is ignored; the request is not accepted, and the requester holds it until req_ready.
- ram_w_en and ram_r_en are never both 1.
- Back-to-back: a new request may be accepted in the IDLE cycle immediately following RESP.

Optional Feature:
- Macro: BYTE_DRAM_CTRL_TIMEOUT_EN.
- Defined:
  - A per-byte counter resets on entering WAIT and increments each WAIT cycle without ram_done.
  - On reaching TIMEOUT, the remaining bytes are aborted and the block goes to RESP with rsp_err=1.
  - rsp_rdata holds the bytes gathered so far, with the remainder 0.
- Not defined: WAIT waits indefinitely, rsp_err is tied to 0, and no counter logic is synthesized.

Test Plan:
- Reset mid-WAIT of a 4-byte read, then release → all outputs at reset values, req_ready=1, no rsp_valid; a subsequent 1-byte read at 0x010 works.
- 4-byte write, addr 0x100, wdata 0xDEADBEEF, ram_done 1 cycle after each strobe → RAM strobes at 0x100..0x103 with data EF, BE, AD, DE; rsp_valid at cycle 9, rsp_err=0.
- 4-byte read of the same bytes, ram_done delayed 3 cycles each → rsp_rdata=0xDEADBEEF at cycle 4·(1+3)+1=17.
- 2-byte read at 0xFFF with bytes 0x12 at 0xFFF and 0x34 at 0x000 → ram_addr sequence FFF then 000; rsp_rdata=0x00003412.
- req_valid held high during a busy 3-byte write plus a spurious ram_done in ISSUE → second request accepted only after RESP; byte count unaffected (3 strobes).
- With BYTE_DRAM_CTRL_TIMEOUT_EN, TIMEOUT=8, ram_done never asserted on the 2nd byte of a read → rsp_valid with rsp_err=1 at 8 WAIT cycles after the second strobe; rsp_rdata holds byte 0 only.
